pixel_scan_sequencer: RTL and testbench

Drives the per-pixel write stream for each frame. On each frame start it walks the screen in raster order, requests one ray trace per pixel from the tracer, and presents the result on the WritePixel/WriteX/WriteY/tbest/best bus. The frame buffer writer and the hit-detection logic consume that bus; this block is its only producer.

---
 rtl/pixel_scan_sequencer_if.sv | 34 +++
 rtl/pixel_scan_sequencer.sv | 132 +++++++++++++
 tb/tb_pixel_scan_sequencer.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_scan_sequencer_if.sv
// Bundle between pixel_scan_sequencer, the ray tracer and the frame-buffer write consumers.
// The sequencer takes the master modport; the tracer/consumer environment takes the slave modport.
interface pixel_scan_sequencer_if;
    logic        frame_clk;
    logic [9:0]  RayX;
    logic [9:0]  RayY;
    logic        trace_start;
    logic        trace_done;
    logic [63:0] trace_t;
    logic [1:0]  trace_best;
    logic [23:0] trace_color;
    logic [9:0]  WriteX;
    logic [9:0]  WriteY;
    logic        WritePixel;
    logic        WriteReady;
    logic [23:0] WriteColor;
    logic [63:0] tbest;
    logic [1:0]  best_out;
    logic        frame_busy;
    logic        frame_done;
    logic        frame_overrun;

    modport master (
        input  frame_clk, trace_done, trace_t, trace_best, trace_color, WriteReady,
        output RayX, RayY, trace_start, WriteX, WriteY, WritePixel, WriteColor,
               tbest, best_out, frame_busy, frame_done, frame_overrun
    );

    modport slave (
        output frame_clk, trace_done, trace_t, trace_best, trace_color, WriteReady,
        input  RayX, RayY, trace_start, WriteX, WriteY, WritePixel, WriteColor,
               tbest, best_out, frame_busy, frame_done, frame_overrun
    );
endinterface

// File: rtl/pixel_scan_sequencer.sv
// Raster-order frame scanner: one trace request per pixel, result presented on the write bus.
// Optional SCAN_CROSSHAIR_EN overlays a white crosshair at the screen centre on WriteColor only.
module pixel_scan_sequencer #(
    parameter int          H_RES    = 640,
    parameter int          V_RES    = 480,
    parameter logic [63:0] MISS_T   = 64'hEFFFFFFFFFFFFFFF,
    parameter logic [23:0] BG_COLOR = 24'h000000
) (
    input logic                    Clk,
    input logic                    Reset_n,
    pixel_scan_sequencer_if.master bus
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WRITE} state_t;

    localparam logic [9:0] X_LAST = 10'(H_RES - 1);
    localparam logic [9:0] Y_LAST = 10'(V_RES - 1);

    state_t      state;
    state_t      next_state;
    logic        old_frame_clk;
    logic        frame_edge;
    logic        accept;
    logic        last_pixel;
    logic [9:0]  x_cnt;
    logic [9:0]  y_cnt;
    logic [23:0] base_color;
    logic [23:0] capture_color;

    assign frame_edge = bus.frame_clk && !old_frame_clk;
    assign last_pixel = (x_cnt == X_LAST) && (y_cnt == Y_LAST);
    assign accept     = (state == WRITE) && bus.WriteReady;
    assign bus.RayX   = x_cnt;
    assign bus.RayY   = y_cnt;

    assign base_color = (bus.trace_t == MISS_T) ? BG_COLOR : bus.trace_color;

`ifdef SCAN_CROSSHAIR_EN
    int   xi;
    int   yi;
    logic on_cross;

    assign xi = int'(x_cnt);
    assign yi = int'(y_cnt);
    assign on_cross = ((yi == V_RES / 2) && (xi >= H_RES / 2 - 8) && (xi <= H_RES / 2 + 8)) ||
                      ((xi == H_RES / 2) && (yi >= V_RES / 2 - 8) && (yi <= V_RES / 2 + 8));
    assign capture_color = on_cross ? 24'hFFFFFF : base_color;
`else
    assign capture_color = base_color;
`endif

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state      = state;
        bus.trace_start = 1'b0;
        bus.WritePixel  = 1'b0;
        case (state)
            IDLE: begin
                if (frame_edge) next_state = ISSUE;
            end
            ISSUE: begin
                bus.trace_start = 1'b1;
                next_state      = WAIT;
            end
            WAIT: begin
                if (bus.trace_done) next_state = WRITE;
            end
            WRITE: begin
                bus.WritePixel = 1'b1;
                if (bus.WriteReady) next_state = last_pixel ? IDLE : ISSUE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Counters only move on frame start or on an accepted write, so RayX/RayY hold through ISSUE and WAIT.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            old_frame_clk     <= 1'b0;
            x_cnt             <= '0;
            y_cnt             <= '0;
            bus.frame_busy    <= 1'b0;
            bus.frame_done    <= 1'b0;
            bus.frame_overrun <= 1'b0;
            bus.WriteX        <= '0;
            bus.WriteY        <= '0;
            bus.WriteColor    <= '0;
            bus.tbest         <= '0;
            bus.best_out      <= '0;
        end else begin
            old_frame_clk     <= bus.frame_clk;
            bus.frame_done    <= accept && last_pixel;
            bus.frame_overrun <= frame_edge && bus.frame_busy;

            if ((state == IDLE) && frame_edge) begin
                bus.frame_busy <= 1'b1;
                x_cnt          <= '0;
                y_cnt          <= '0;
            end

            if (accept) begin
                if (last_pixel) begin
                    bus.frame_busy <= 1'b0;
                    x_cnt          <= '0;
                    y_cnt          <= '0;
                end else if (x_cnt == X_LAST) begin
                    x_cnt <= '0;
                    y_cnt <= y_cnt + 10'd1;
                end else begin
                    x_cnt <= x_cnt + 10'd1;
                end
            end

            // Write data is captured only on the WAIT-to-WRITE transition and held until accepted.
            if ((state == WAIT) && bus.trace_done) begin
                bus.WriteX     <= x_cnt;
                bus.WriteY     <= y_cnt;
                bus.WriteColor <= capture_color;
                bus.tbest      <= bus.trace_t;
                bus.best_out   <= bus.trace_best;
            end
        end
    end

endmodule

// File: tb/tb_pixel_scan_sequencer.sv
// Directed bench for pixel_scan_sequencer on a 4x2 screen with a 1-cycle-latency tracer model.
module tb_pixel_scan_sequencer;

    localparam logic [63:0] MISS   = 64'hEFFFFFFFFFFFFFFF;
    localparam logic [23:0] BG     = 24'h00A5A5;
    localparam logic [23:0] HITCOL = 24'h123456;

    logic Clk;
    logic Reset_n;

    pixel_scan_sequencer_if bus ();

    pixel_scan_sequencer #(
        .H_RES   (4),
        .V_RES   (2),
        .MISS_T  (MISS),
        .BG_COLOR(BG)
    ) dut (
        .Clk    (Clk),
        .Reset_n(Reset_n),
        .bus    (bus)
    );

    int total  = 0;
    int passed = 0;
    int failed = 0;
    int cyc    = 0;
    int done_cnt = 0;
    int ovr_cnt  = 0;

    logic [63:0] tr_t     = 64'd5;
    logic [23:0] tr_color = HITCOL;
    logic [1:0]  tr_best  = 2'd2;

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    always @(posedge Clk) cyc++;

    always @(negedge Clk) begin
        if (bus.frame_done)    done_cnt++;
        if (bus.frame_overrun) ovr_cnt++;
    end

    // Tracer model: answers each trace_start with a one-cycle trace_done during the following cycle.
    initial begin
        int cnt;
        cnt = 0;
        bus.trace_done  = 1'b0;
        bus.trace_t     = '0;
        bus.trace_best  = '0;
        bus.trace_color = '0;
        forever begin
            @(negedge Clk);
            bus.trace_done = 1'b0;
            if (!Reset_n) begin
                cnt = 0;
            end else begin
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        bus.trace_done  = 1'b1;
                        bus.trace_t     = tr_t;
                        bus.trace_color = tr_color;
                        bus.trace_best  = tr_best;
                    end
                end
                if (bus.trace_start) cnt = 1;
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected) passed++;
        else begin
            failed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic fclk, input logic wready, input int cycles);
        bus.frame_clk  = fclk;
        bus.WriteReady = wready;
        repeat (cycles) @(negedge Clk);
    endtask

    task automatic waitWrite();
        int n;
        n = 0;
        do begin
            @(negedge Clk);
            n++;
        end while (!bus.WritePixel && n < 30);
        checkOutput("write_seen", bus.WritePixel, 1'b1);
    endtask

    initial begin
        int prev_cyc;
        int ex;
        int ey;

        Reset_n        = 1'b0;
        bus.frame_clk  = 1'b0;
        bus.WriteReady = 1'b1;
        repeat (2) @(negedge Clk);
        checkOutput("rst_trace_start", bus.trace_start, 0);
        checkOutput("rst_write_pixel", bus.WritePixel, 0);
        checkOutput("rst_busy", bus.frame_busy, 0);
        checkOutput("rst_tbest", bus.tbest, 0);
        Reset_n = 1'b1;
        applyStimulus(0, 1, 3);
        checkOutput("idle_no_start", bus.trace_start, 0);

        // Frame 1: pixels 0-3 hit, 4-7 miss; writes 3 cycles apart.
        $display("[TB] frame 1: raster order, hit/miss colours");
        applyStimulus(1, 1, 1);
        checkOutput("f1_start", bus.trace_start, 1);
        checkOutput("f1_rayx", bus.RayX, 0);
        checkOutput("f1_rayy", bus.RayY, 0);
        checkOutput("f1_busy", bus.frame_busy, 1);
        applyStimulus(0, 1, 0);
        prev_cyc = 0;
        for (int k = 0; k < 8; k++) begin
            ex = k % 4;
            ey = k / 4;
            waitWrite();
            checkOutput("f1_wx", bus.WriteX, 10'(ex));
            checkOutput("f1_wy", bus.WriteY, 10'(ey));
            checkOutput("f1_color", bus.WriteColor, (k < 4) ? HITCOL : BG);
            checkOutput("f1_tbest", bus.tbest, (k < 4) ? 64'd5 : MISS);
            checkOutput("f1_best", bus.best_out, 2'd2);
            if (k > 0) checkOutput("f1_spacing", cyc - prev_cyc, 3);
            prev_cyc = cyc;
            if (k == 3) tr_t = MISS;
        end
        @(negedge Clk);
        checkOutput("f1_done", bus.frame_done, 1);
        checkOutput("f1_busy_clr", bus.frame_busy, 0);
        @(negedge Clk);
        checkOutput("f1_done_pulse", bus.frame_done, 0);
        checkOutput("f1_done_cnt", done_cnt, 1);

        // Frame 2: stall first write, then overrun edges at (2,1) and on the final accept.
        $display("[TB] frame 2: backpressure and overrun");
        tr_t = 64'd5;
        tr_best = 2'd1;
        applyStimulus(1, 0, 1);
        applyStimulus(0, 0, 0);
        waitWrite();
        for (int i = 0; i < 5; i++) begin
            checkOutput("stall_wp", bus.WritePixel, 1);
            checkOutput("stall_wx", bus.WriteX, 0);
            checkOutput("stall_no_start", bus.trace_start, 0);
            checkOutput("stall_rayx", bus.RayX, 0);
            if (i == 4) bus.WriteReady = 1'b1;
            else @(negedge Clk);
        end
        checkOutput("stall_best", bus.best_out, 2'd1);
        @(negedge Clk);
        checkOutput("after_accept_start", bus.trace_start, 1);
        checkOutput("after_accept_rayx", bus.RayX, 1);
        for (int k = 1; k < 8; k++) begin
            waitWrite();
            checkOutput("f2_wx", bus.WriteX, 10'(k % 4));
            checkOutput("f2_wy", bus.WriteY, 10'(k / 4));
            if (k == 6) begin
                applyStimulus(1, 1, 1);
                checkOutput("ovr_pulse", bus.frame_overrun, 1);
                checkOutput("ovr_busy", bus.frame_busy, 1);
                applyStimulus(0, 1, 1);
                checkOutput("ovr_once", bus.frame_overrun, 0);
            end
            if (k == 7) begin
                applyStimulus(1, 1, 1);
                checkOutput("last_done", bus.frame_done, 1);
                checkOutput("last_ovr", bus.frame_overrun, 1);
                checkOutput("last_busy", bus.frame_busy, 0);
                applyStimulus(0, 1, 0);
            end
        end
        repeat (4) @(negedge Clk);
        checkOutput("no_restart_busy", bus.frame_busy, 0);
        checkOutput("no_restart_wp", bus.WritePixel, 0);
        checkOutput("f2_done_cnt", done_cnt, 2);
        checkOutput("f2_ovr_cnt", ovr_cnt, 2);

        // Frame 3: asynchronous reset mid-frame at pixel (1,1), then a clean restart.
        $display("[TB] frame 3: reset mid-frame");
        tr_t = MISS;
        applyStimulus(1, 1, 1);
        applyStimulus(0, 1, 0);
        for (int k = 0; k < 6; k++) waitWrite();
        checkOutput("pre_rst_wx", bus.WriteX, 1);
        checkOutput("pre_rst_wy", bus.WriteY, 1);
        Reset_n = 1'b0;
        #1;
        checkOutput("mid_rst_wp", bus.WritePixel, 0);
        checkOutput("mid_rst_busy", bus.frame_busy, 0);
        checkOutput("mid_rst_wx", bus.WriteX, 0);
        checkOutput("mid_rst_wy", bus.WriteY, 0);
        checkOutput("mid_rst_color", bus.WriteColor, 0);
        checkOutput("mid_rst_tbest", bus.tbest, 0);
        checkOutput("mid_rst_best", bus.best_out, 0);
        checkOutput("mid_rst_rayx", bus.RayX, 0);
        checkOutput("mid_rst_rayy", bus.RayY, 0);
        checkOutput("mid_rst_start", bus.trace_start, 0);
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        applyStimulus(0, 1, 3);
        checkOutput("post_rst_idle", bus.frame_busy, 0);
        applyStimulus(1, 1, 1);
        checkOutput("restart_start", bus.trace_start, 1);
        checkOutput("restart_rayx", bus.RayX, 0);
        checkOutput("restart_rayy", bus.RayY, 0);
        applyStimulus(0, 1, 0);
        waitWrite();
        checkOutput("restart_wx", bus.WriteX, 0);
        checkOutput("restart_wy", bus.WriteY, 0);
        checkOutput("restart_color", bus.WriteColor, BG);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
